// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port word memory between instruction
// fetch (IF), MEM-stage data access (D) and a debug/loader port (DBG).
// One access is granted per clock; read data returns one cycle later and is
// routed to whoever was granted the read.
//
// rsel (response owner) values:
//   state   | meaning
//   RS_NONE | no read in flight, all rvalid low
//   RS_IF   | last cycle granted an IF read, if_rvalid high
//   RS_D    | last cycle granted a D load, d_rvalid high
//   RS_DBG  | last cycle granted a DBG read, dbg_rvalid high
module mem_port_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          halt,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    RS_NONE = 2'd0,
    RS_IF   = 2'd1,
    RS_D    = 2'd2,
    RS_DBG  = 2'd3
  } rsel_t;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  rsel_t      rsel_q, rsel_d;
  logic [3:0] wait_cnt, wait_nxt;
  logic       starve;

  assign starve = (wait_cnt == WAIT_MAX);

  // Fixed priority grant: DBG, starved IF, D, then IF; nothing while in reset.
  always_comb begin
    if_gnt  = 1'b0;
    d_gnt   = 1'b0;
    dbg_gnt = 1'b0;
    if (rst_n) begin
      if (dbg_req) begin
        dbg_gnt = 1'b1;
      end else if (if_req && starve && !halt) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end else if (if_req && !halt) begin
        if_gnt = 1'b1;
      end
    end
  end

  // Memory port mux from the winner; idle port drives zeros.
  always_comb begin
    mem_en    = if_gnt | d_gnt | dbg_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  // Next response owner and fetch wait count.
  always_comb begin
    rsel_d   = RS_NONE;
    wait_nxt = 4'd0;
    if (dbg_gnt && !dbg_we) begin
      rsel_d = RS_DBG;
    end else if (d_gnt && !d_we) begin
      rsel_d = RS_D;
    end else if (if_gnt) begin
      rsel_d = RS_IF;
    end
    // A denied fetch counts up until it saturates; any grant, drop or halt clears it.
    if (if_req && !if_gnt && !halt) begin
      wait_nxt = starve ? wait_cnt : wait_cnt + 4'd1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsel_q   <= RS_NONE;
      wait_cnt <= 4'd0;
    end else begin
      rsel_q   <= rsel_d;
      wait_cnt <= wait_nxt;
    end
  end

  assign if_rvalid  = (rsel_q == RS_IF);
  assign d_rvalid   = (rsel_q == RS_D);
  assign dbg_rvalid = (rsel_q == RS_DBG);
  assign if_rdata   = if_rvalid  ? mem_rdata : '0;
  assign d_rdata    = d_rvalid   ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a behavioural memory serves the port, a
// reference model predicts grants and responses every cycle, and directed
// scenarios pin literal values.
module tb_mem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MAX_WAIT = 4;

  logic clk, rst_n, halt;
  logic if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  logic [DW-1:0] tb_mem  [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory behind the port: writes land at the edge, reads return next cycle.
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= tb_mem[mem_addr];
    else                   mem_rdata <= 32'hdead_beef;
    if (mem_en && mem_we) tb_mem[mem_addr] = mem_wdata;
  end

  // Reference model: who should win now, what should come back next cycle.
  int            m_wait = 0;
  int            m_owner = 0;
  logic [DW-1:0] m_data = '0;

  always @(negedge clk) begin
    int            w;
    logic          ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    if (chk_en) begin
      w = 0;
      if (rst_n) begin
        if (dbg_req) w = 3;
        else if (if_req && !halt && m_wait >= MAX_WAIT) w = 1;
        else if (d_req) w = 2;
        else if (if_req && !halt) w = 1;
      end
      ewe = 1'b0; ea = '0; ewd = '0;
      if (w == 3) begin ewe = dbg_we; ea = dbg_addr; ewd = dbg_wdata; end
      if (w == 2) begin ewe = d_we;   ea = d_addr;   ewd = d_wdata;   end
      if (w == 1) begin ea = if_addr; end
      chk("m_if_gnt",    if_gnt,    w == 1);
      chk("m_d_gnt",     d_gnt,     w == 2);
      chk("m_dbg_gnt",   dbg_gnt,   w == 3);
      chk("m_mem_en",    mem_en,    w != 0);
      chk("m_mem_we",    mem_we,    ewe);
      chk("m_mem_addr",  mem_addr,  ea);
      chk("m_mem_wdata", mem_wdata, ewd);
      chk("m_if_rvalid",  if_rvalid,  m_owner == 1);
      chk("m_d_rvalid",   d_rvalid,   m_owner == 2);
      chk("m_dbg_rvalid", dbg_rvalid, m_owner == 3);
      chk("m_if_rdata",   if_rdata,   (m_owner == 1) ? m_data : '0);
      chk("m_d_rdata",    d_rdata,    (m_owner == 2) ? m_data : '0);
      chk("m_dbg_rdata",  dbg_rdata,  (m_owner == 3) ? m_data : '0);
      if (!rst_n) begin
        m_owner = 0;
        m_wait  = 0;
      end else begin
        m_owner = (w != 0 && !ewe) ? w : 0;
        m_data  = ref_mem[ea];
        if (w != 0 && ewe) ref_mem[ea] = ewd;
        if (if_req && !halt && w != 1) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
        else m_wait = 0;
      end
    end
  end

  initial begin
    string seq;
    for (int i = 0; i < (1 << AW); i++) begin
      tb_mem[i]  = 32'h1000_0000 + 32'(i * 7);
      ref_mem[i] = 32'h1000_0000 + 32'(i * 7);
    end
    tb_mem[120]  = 32'd85;
    ref_mem[120] = 32'd85;

    // Reset with every requester asking.
    rst_n = 1'b0; halt = 1'b0;
    if_req = 1'b1; if_addr = '0;
    d_req = 1'b1; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'd5; dbg_wdata = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    #1;
    chk("rst_gnts", {if_gnt, d_gnt, dbg_gnt, mem_en, mem_we}, 5'b0);
    step(); #1;
    chk("rst_gnts2", {if_gnt, d_gnt, dbg_gnt, mem_en}, 4'b0);
    chk("rst_rvalid", {if_rvalid, d_rvalid, dbg_rvalid}, 3'b0);
    step(); rst_n = 1'b1; #1;
    chk("rel_first_dbg", {if_gnt, d_gnt, dbg_gnt}, 3'b001);
    step(); if_req = 1'b0; d_req = 1'b0; dbg_req = 1'b0; #1;
    chk("rel_dbg_rvalid", dbg_rvalid, 1'b1);
    chk("rel_dbg_rdata", dbg_rdata, 32'h1000_0023);

    // Single reads: IF at 0, then D at 120.
    step(); if_req = 1'b1; if_addr = 10'd0; #1;
    chk("rd_if_gnt", if_gnt, 1'b1);
    step(); if_req = 1'b0; d_req = 1'b1; d_addr = 10'd120; #1;
    chk("rd_if_rvalid", if_rvalid, 1'b1);
    chk("rd_if_rdata", if_rdata, 32'h1000_0000);
    chk("rd_d_gnt", d_gnt, 1'b1);
    step(); d_req = 1'b0; #1;
    chk("rd_d_rvalid", d_rvalid, 1'b1);
    chk("rd_d_rdata", d_rdata, 32'd85);
    chk("rd_if_rvalid_off", if_rvalid, 1'b0);

    // Store then load of the same address.
    step(); d_req = 1'b1; d_we = 1'b1; d_addr = 10'd121; d_wdata = 32'd86; #1;
    chk("wr_d_gnt", d_gnt, 1'b1);
    chk("wr_mem_we", mem_we, 1'b1);
    step(); d_we = 1'b0; #1;
    chk("wr_no_rvalid", d_rvalid, 1'b0);
    chk("wr_rd_gnt", d_gnt, 1'b1);
    step(); d_req = 1'b0; #1;
    chk("wr_rd_rvalid", d_rvalid, 1'b1);
    chk("wr_rd_rdata", d_rdata, 32'd86);

    // Starvation guard under continuous data traffic.
    step(); d_req = 1'b1; d_addr = 10'd10; if_req = 1'b1; if_addr = 10'd1;
    seq = "";
    for (int i = 0; i < 10; i++) begin
      #1;
      if (if_gnt) seq = {seq, "I"};
      else if (d_gnt) seq = {seq, "D"};
      else seq = {seq, "-"};
      step();
    end
    n_cmp++;
    if (seq != "DDDDIDDDDI") begin
      n_bad++;
      $display("FAIL starve_pattern: got %s expected DDDDIDDDDI", seq);
    end
    if_req = 1'b0; d_req = 1'b0;

    // Halt: in-flight fetch completes, then fetch frozen while D/DBG run.
    step(); if_req = 1'b1; if_addr = 10'd3; #1;
    chk("h_if_gnt", if_gnt, 1'b1);
    step(); halt = 1'b1; if_addr = 10'd4; d_req = 1'b1; d_addr = 10'd120; #1;
    chk("h_if_rvalid", if_rvalid, 1'b1);
    chk("h_if_rdata", if_rdata, 32'h1000_0015);
    chk("h_if_gnt_off", if_gnt, 1'b0);
    chk("h_d_gnt", d_gnt, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(); d_addr = 10'(i); dbg_req = (i == 5); dbg_addr = 10'd121; #1;
      chk("h_if_frozen", if_gnt, 1'b0);
      chk("h_wait_cnt", dut.wait_cnt, 4'd0);
    end
    step(); halt = 1'b0; if_req = 1'b0; d_req = 1'b0; dbg_req = 1'b0;

    // Debug priority over a starved fetch and pending data.
    step(); d_req = 1'b1; d_addr = 10'd20; if_req = 1'b1; if_addr = 10'd9;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("p_d_first", d_gnt, 1'b1);
      step();
    end
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'd7; dbg_wdata = 32'hfc00_0000; #1;
    chk("p_dbg_gnt", dbg_gnt, 1'b1);
    chk("p_mem_we", mem_we, 1'b1);
    chk("p_mem_addr", mem_addr, 10'd7);
    chk("p_mem_wdata", mem_wdata, 32'hfc00_0000);
    chk("p_others_off", {if_gnt, d_gnt}, 2'b00);
    step(); dbg_we = 1'b0; #1;
    chk("p_dbg_gnt2", dbg_gnt, 1'b1);
    chk("p_others_off2", {if_gnt, d_gnt}, 2'b00);
    chk("p_wait_sat", dut.wait_cnt, 4'd4);
    step(); dbg_req = 1'b0; #1;
    chk("p_dbg_rvalid", dbg_rvalid, 1'b1);
    chk("p_dbg_rdata", dbg_rdata, 32'hfc00_0000);
    chk("p_if_after", if_gnt, 1'b1);
    step(); #1;
    chk("p_d_after", d_gnt, 1'b1);
    step(); if_req = 1'b0; d_req = 1'b0;

    // Mixed traffic checked by the model alone.
    for (int i = 0; i < 60; i++) begin
      step();
      dbg_req   = ($urandom_range(0, 5) == 0);
      dbg_we    = 1'($urandom_range(0, 1));
      dbg_addr  = 10'($urandom_range(0, 127));
      dbg_wdata = $urandom;
      d_req     = 1'($urandom_range(0, 1));
      d_we      = 1'($urandom_range(0, 1));
      d_addr    = 10'($urandom_range(0, 127));
      d_wdata   = $urandom;
      if_req    = 1'($urandom_range(0, 1));
      if_addr   = 10'($urandom_range(0, 127));
      halt      = ($urandom_range(0, 7) == 0);
    end

    // Reset landing on a would-be read grant drops it.
    step(); halt = 1'b0; if_req = 1'b0; dbg_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'd120; rst_n = 1'b0; #1;
    chk("r_d_gnt", d_gnt, 1'b0);
    chk("r_mem_en", mem_en, 1'b0);
    step(); rst_n = 1'b1; d_req = 1'b0; #1;
    chk("r_d_rvalid", d_rvalid, 1'b0);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
